store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the CPU store path and the word-wide data memory. Accepts byte-enabled store requests: word address, 4-bit write enable, lane-replicated data. Queues them in order and drains them one word per handshake to the memory port. Provides combinational byte-lane forwarding to the load path so loads see pending stores.

## Interface
Parameters:
- DEPTH, 4, number of entries (power of two, 2..16)
- ADDR_W, 12, word-address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept store this cycle
- st_addr  in  ADDR_W  store word address
- st_we  in  4  byte write enables; bit 3 = byte 0 (MSB lane)
- st_data  in  32  store data, already lane-aligned
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  ADDR_W  head entry address
- mem_we  out  4  head entry byte enables
- mem_data  out  32  head entry data
- ld_addr  in  ADDR_W  load probe word address
- ld_hit  out  4  per-lane forward hit, same lane order as st_we
- ld_data  out  32  forwarded bytes; lanes with ld_hit=0 are 0
- flush  in  1  stop accepting stores until buffer drains
- empty  out  1  no entries pending

## Operation
- Circular FIFO: head pointer, tail pointer, count (width clog2(DEPTH)+1).
- Store accept when st_valid & st_ready.
- st_we=4'b0000 is accepted and discarded: no entry written, count unchanged.
- Non-empty store normally writes the entry at tail, tail+1 mod DEPTH, count+1.
- Drain when mem_valid & mem_ready: head+1 mod DEPTH, count−1.
- Accept and drain in the same cycle: count unchanged, pointers both advance.
- st_ready = (count < DEPTH) & ~flush. Depends on registered state and flush only; no path from mem_ready. A full buffer refuses a store even while draining.
- mem_valid = (count != 0). mem_addr/we/data come from the head entry and stay stable while mem_valid & ~mem_ready.
- empty = (count == 0).
- Forwarding is combinational from current entries only. A store accepted in cycle N is visible to probes from cycle N+1.
  - Per lane, the newest valid entry with matching address and that lane's we bit supplies the byte.
  - The head entry counts even in its drain cycle.
- flush: st_ready stays low while flush is high. empty is the completion indication; the block has no separate done signal.
- Pointer wrap: modulo DEPTH with no bubble. Count saturation at DEPTH is guaranteed by st_ready.

## Timing
- Reset values: count=0, head=tail=0, mem_valid=0, mem_addr=0, mem_we=0, mem_data=0, empty=1.
  - st_ready=1 when flush=0.
  - ld_hit=0, ld_data=0.
  - Entry storage valid bits are cleared; data contents don't care.
- Reset mid-operation discards all pending stores. Memory must not see a partial transaction: mem_valid drops asynchronously.
- Latency store→mem_valid: 1 cycle when empty.
- Throughput: one store and one drain per cycle.
- Store→forward visibility: 1 cycle.

## Configuration
- STORE_BUF_COALESCE_EN defined: an accepted store may merge into the newest entry instead of allocating one. Merge happens when the newest entry's address equals st_addr and that entry is not the head (count ≥ 2).
  - Merge rule: lanes with the new we=1 take the new data; the entry's we becomes the OR of old and new.
  - Count and tail are unchanged on a merge.
  - st_ready is also 1 when full if the store would merge; this evaluation uses st_valid/st_addr, never mem_ready.
- Not defined: every non-empty store allocates an entry. st_ready follows the base rule.

## Structure
- Package store_buf_pkg:
  - entry typedef (addr, we[3:0], data[31:0], valid)
  - lane index constants (lane 0 = bits 31:24)
  - pointer-width function
- Sub-module store_buf_fwd: combinational newest-first per-lane priority select over the entry array. Takes entries plus head/count; outputs ld_hit/ld_data.

## Test plan
- Reset, then SW addr 0x010 we=1111 data 0xDEADBEEF with mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x010, mem_we=1111, mem_data=0xDEADBEEF.
  - Outputs held 5 cycles; empty=0.
  - Probe 0x010 gives ld_hit=1111, ld_data=0xDEADBEEF.
- Fill 4 stores with mem_ready=0 -> st_ready=0 after the 4th.
  - Raise mem_ready -> drains in order, 4 consecutive cycles, then empty=1.
  - st_ready stays 0 in the full cycle even with mem_ready=1.
- SB addr 0x020 we=0010 data 0x55555555, then SB addr 0x020 we=1000 data 0xAAAAAAAA -> probe 0x020 gives ld_hit=1010, ld_data=0xAA005500.
  - With STORE_BUF_COALESCE_EN and a pending head at another address, the second store merges: count=2, not 3, and drained we=1010.
- Store with we=0000 -> accepted, count unchanged, no mem transaction.
- DEPTH=4, 10 stores with mem_ready toggling each cycle -> all 10 drained in order across pointer wrap, none lost or duplicated.
- Reset asserted with 3 entries pending -> mem_valid=0 and empty=1 immediately. After release, no stale entries drain.

Source files
------------

// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the store buffer.
// An entry holds one posted word write; lane 0 is the MSB byte (bits 31:24)
// and is enabled by we[3], lane 3 is bits 7:0 enabled by we[0].
package store_buf_pkg;

  // Entries keep a full-width address so the type is independent of ADDR_W.
  localparam int ADDR_MAX_W = 32;

  // Byte lanes, numbered from the most significant byte.
  localparam int LANE_FIRST = 0;
  localparam int LANE_LAST  = 3;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [3:0]            we;
    logic [31:0]           data;
    logic                  valid;
  } entry_t;

  // Lowest data bit of a lane.
  function automatic int lane_lsb(input int lane);
    return 24 - 8 * lane;
  endfunction

  // Write-enable bit that controls a lane.
  function automatic int lane_we_bit(input int lane);
    return 3 - lane;
  endfunction

  // Pointer width for a power-of-two depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-request and memory-drain channels of the store buffer.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid and its payload stable until that
// edge; ready may be high without valid and carries no obligation.
interface store_buffer_if #(parameter int ADDR_W = 12);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [3:0]        st_we;
  logic [31:0]       st_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_data;

  // Buffer side: sinks stores, sources memory writes.
  modport slave (
    input  st_valid, st_addr, st_we, st_data, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_we, mem_data
  );

  // Environment side: CPU store path plus data memory.
  modport master (
    output st_valid, st_addr, st_we, st_data, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_we, mem_data
  );
endinterface

// File: rtl/store_buf_fwd.sv
// Load-path forwarding: per byte lane, the newest live entry whose address
// matches the probe and whose enable covers that lane supplies the byte.
import store_buf_pkg::*;

module store_buf_fwd #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 12,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = PW + 1
) (
  input  entry_t            entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [3:0]        ld_hit,
  output logic [31:0]       ld_data
);

  logic [PW-1:0] idx;
  entry_t        e;

  // Walk oldest to newest so later matches overwrite earlier ones.
  always_comb begin
    ld_hit  = '0;
    ld_data = '0;
    idx     = '0;
    e       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      e   = entries[idx];
      if ((CW'(i) < count) && e.valid && (e.addr == ADDR_MAX_W'(ld_addr))) begin
        for (int lane = LANE_FIRST; lane <= LANE_LAST; lane++) begin
          if (e.we[lane_we_bit(lane)]) begin
            ld_hit[lane_we_bit(lane)]     = 1'b1;
            ld_data[lane_lsb(lane) +: 8]  = e.data[lane_lsb(lane) +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order circular FIFO of byte-enabled word
// stores, drained one entry per memory handshake, with byte forwarding to
// the load path.
// Build option STORE_BUF_COALESCE_EN: a store to the same address as the
// newest non-head entry merges into it instead of allocating.
import store_buf_pkg::*;

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  store_buffer_if.slave     bus,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [3:0]        ld_hit,
  output logic [31:0]       ld_data,
  input  logic              flush,
  output logic              empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        entries [DEPTH];
  entry_t        head_e;
  logic [PW-1:0] head, tail, newest;
  logic [CW-1:0] count;
  logic          st_fire, mem_fire, st_live, merge, alloc;

  assign newest  = tail - 1'b1;
  assign st_live = |bus.st_we;

`ifdef STORE_BUF_COALESCE_EN
  // The newest entry can absorb the store only when it is not the head,
  // so the entry being presented to memory never changes under it.
  logic merge_ok;
  assign merge_ok = bus.st_valid & st_live & (count >= CW'(2)) &
                    (entries[newest].addr == ADDR_MAX_W'(bus.st_addr));
  assign bus.st_ready = ((count < FULL_CNT) | merge_ok) & ~flush;
  assign merge        = st_fire & merge_ok;
`else
  assign bus.st_ready = (count < FULL_CNT) & ~flush;
  assign merge        = 1'b0;
`endif

  // All-zero enables are accepted but never occupy an entry.
  assign st_fire = bus.st_valid & bus.st_ready;
  assign alloc   = st_fire & st_live & ~merge;

  assign bus.mem_valid = (count != '0);
  assign mem_fire      = bus.mem_valid & bus.mem_ready;
  assign empty         = (count == '0);

  // Head payload is gated so the port reads zero whenever nothing is pending.
  assign head_e       = entries[head];
  assign bus.mem_addr = bus.mem_valid ? head_e.addr[ADDR_W-1:0] : '0;
  assign bus.mem_we   = bus.mem_valid ? head_e.we : '0;
  assign bus.mem_data = bus.mem_valid ? head_e.data : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)    tail <= tail + 1'b1;
      if (mem_fire) head <= head + 1'b1;
      case ({alloc, mem_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: allocate at tail, retire at head, merge into newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (mem_fire) entries[head].valid <= 1'b0;
      if (alloc) begin
        entries[tail] <= '{addr:  ADDR_MAX_W'(bus.st_addr),
                           we:    bus.st_we,
                           data:  bus.st_data,
                           valid: 1'b1};
      end
      if (merge) begin
        entries[newest].we <= entries[newest].we | bus.st_we;
        for (int lane = LANE_FIRST; lane <= LANE_LAST; lane++) begin
          if (bus.st_we[lane_we_bit(lane)])
            entries[newest].data[lane_lsb(lane) +: 8] <= bus.st_data[lane_lsb(lane) +: 8];
        end
      end
    end
  end

  store_buf_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset state, hold, fill/drain, lane
// forwarding, discarded stores, pointer wrap, flush and mid-run reset.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_hit;
  logic [31:0]       ld_data;
  logic              flush;
  logic              empty;

  int checks = 0;
  int errors = 0;
  int drains = 0;
  logic tog_en = 1'b0;
  logic [47:0] exp_q[$];

  store_buffer_if #(.ADDR_W(ADDR_W)) bus();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .ld_data (ld_data),
    .flush   (flush),
    .empty   (empty)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [ADDR_W-1:0] a, input logic [3:0] w,
                          input logic [31:0] d, input bit push);
    int n;
    n = 0;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_we    = w;
    bus.st_data  = d;
    while (bus.st_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("st_accept_in_time", 64'(n < 100), 64'd1);
    if (push) exp_q.push_back({a, w, d});
    tick();
    bus.st_valid = 1'b0;
    bus.st_we    = 4'b0000;
  endtask

  task automatic wait_empty(output int n);
    n = 0;
    while (empty !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // scoreboard: every memory handshake must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) begin
      drains++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL drain_unexpected observed %0h expected none",
               {bus.mem_addr, bus.mem_we, bus.mem_data});
      end else begin
        check("drain_entry", 64'({bus.mem_addr, bus.mem_we, bus.mem_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // mem_ready toggler for the wrap test
  initial begin
    wait (tog_en);
    while (tog_en) begin
      tick();
      bus.mem_ready = ~bus.mem_ready;
    end
  end

  initial begin
    int n;
    int exp_n;
    int d0;
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_we     = '0;
    bus.st_data   = '0;
    bus.mem_ready = 1'b0;
    ld_addr       = '0;
    flush         = 1'b0;

    // reset state
    tick(2);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_data", 64'(bus.mem_data), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_st_ready", 64'(bus.st_ready), 64'd1);
    check("rst_ld_hit", 64'(ld_hit), 64'd0);
    check("rst_ld_data", 64'(ld_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // single word store, held while memory stalls
    do_store(12'h010, 4'b1111, 32'hDEADBEEF, 1'b1);
    check("t1_mem_valid", 64'(bus.mem_valid), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'h010);
    check("t1_mem_we", 64'(bus.mem_we), 64'hF);
    check("t1_mem_data", 64'(bus.mem_data), 64'hDEADBEEF);
    check("t1_empty", 64'(empty), 64'd0);
    ld_addr = 12'h010;
    #1;
    check("t1_ld_hit", 64'(ld_hit), 64'hF);
    check("t1_ld_data", 64'(ld_data), 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_valid", 64'(bus.mem_valid), 64'd1);
      check("t1_hold_data", 64'(bus.mem_data), 64'hDEADBEEF);
    end
    bus.mem_ready = 1'b1;
    wait_empty(n);
    check("t1_drain_cycles", 64'(n), 64'd1);
    bus.mem_ready = 1'b0;
    #1;
    check("t1_ld_after_drain", 64'(ld_hit), 64'd0);

    // fill to full, then drain in order
    for (int i = 0; i < 4; i++)
      do_store(12'(12'h100 + i), 4'b1111, 32'(32'h11111111 * (i + 1)), 1'b1);
    check("t2_full_ready", 64'(bus.st_ready), 64'd0);
    check("t2_full_empty", 64'(empty), 64'd0);
    bus.mem_ready = 1'b1;
    #1;
    check("t2_full_ready_while_drain", 64'(bus.st_ready), 64'd0);
    wait_empty(n);
    check("t2_drain_cycles", 64'(n), 64'd4);
    bus.mem_ready = 1'b0;
    #1;
    check("t2_ready_after_drain", 64'(bus.st_ready), 64'd1);

    // byte-lane forwarding across two partial stores
    do_store(12'h030, 4'b1111, 32'h01020304, 1'b1);
    do_store(12'h020, 4'b0010, 32'h55555555, 1'b0);
    do_store(12'h020, 4'b1000, 32'hAAAAAAAA, 1'b0);
`ifdef STORE_BUF_COALESCE_EN
    exp_q.push_back({12'h020, 4'b1010, 32'hAA555555});
    exp_n = 2;
`else
    exp_q.push_back({12'h020, 4'b0010, 32'h55555555});
    exp_q.push_back({12'h020, 4'b1000, 32'hAAAAAAAA});
    exp_n = 3;
`endif
    ld_addr = 12'h020;
    #1;
    check("t3_ld_hit", 64'(ld_hit), 64'b1010);
    check("t3_ld_data", 64'(ld_data), 64'hAA005500);
    ld_addr = 12'h030;
    #1;
    check("t3_ld_hit_head", 64'(ld_hit), 64'hF);
    check("t3_ld_data_head", 64'(ld_data), 64'h01020304);
    ld_addr = 12'h040;
    #1;
    check("t3_ld_miss_hit", 64'(ld_hit), 64'd0);
    check("t3_ld_miss_data", 64'(ld_data), 64'd0);
    bus.mem_ready = 1'b1;
    wait_empty(n);
    check("t3_drain_cycles", 64'(n), 64'(exp_n));
    bus.mem_ready = 1'b0;

    // newest store wins per lane
    do_store(12'h050, 4'b1111, 32'h11111111, 1'b1);
    do_store(12'h050, 4'b0100, 32'h22222222, 1'b1);
    ld_addr = 12'h050;
    #1;
    check("t3b_ld_hit", 64'(ld_hit), 64'hF);
    check("t3b_ld_data", 64'(ld_data), 64'h11221111);
    bus.mem_ready = 1'b1;
    wait_empty(n);
    check("t3b_drain_cycles", 64'(n), 64'd2);
    bus.mem_ready = 1'b0;

    // all-zero enables: accepted, nothing queued
    do_store(12'h060, 4'b0000, 32'h12345678, 1'b0);
    check("t4_empty", 64'(empty), 64'd1);
    check("t4_mem_valid", 64'(bus.mem_valid), 64'd0);
    ld_addr = 12'h060;
    #1;
    check("t4_ld_hit", 64'(ld_hit), 64'd0);
    tick(2);
    check("t4_empty_later", 64'(empty), 64'd1);

    // ten stores with mem_ready toggling: pointer wrap
    d0 = drains;
    tog_en = 1'b1;
    for (int i = 0; i < 10; i++)
      do_store(12'(12'h200 + i), 4'b1111, 32'(32'hC0DE0000 + i), 1'b1);
    wait_empty(n);
    check("t5_drained_in_time", 64'(n < 100), 64'd1);
    tog_en = 1'b0;
    tick(2);
    bus.mem_ready = 1'b0;
    check("t5_drain_total", 64'(drains - d0), 64'd10);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // flush: refuse stores until drained
    do_store(12'h300, 4'b1111, 32'h30303030, 1'b1);
    do_store(12'h301, 4'b0001, 32'h31313131, 1'b1);
    flush = 1'b1;
    #1;
    check("t6_flush_ready", 64'(bus.st_ready), 64'd0);
    bus.mem_ready = 1'b1;
    wait_empty(n);
    check("t6_flush_drain_cycles", 64'(n), 64'd2);
    check("t6_flush_ready_empty", 64'(bus.st_ready), 64'd0);
    flush = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("t6_unflush_ready", 64'(bus.st_ready), 64'd1);

    // reset with pending entries
    do_store(12'h400, 4'b1111, 32'h40404040, 1'b1);
    do_store(12'h401, 4'b1111, 32'h41414141, 1'b1);
    do_store(12'h402, 4'b1111, 32'h42424242, 1'b1);
    check("t7_pending_valid", 64'(bus.mem_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("t7_rst_empty", 64'(empty), 64'd1);
    check("t7_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    ld_addr = 12'h400;
    #1;
    check("t7_rst_ld_hit", 64'(ld_hit), 64'd0);
    exp_q.delete();
    d0 = drains;
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick(5);
    check("t7_post_empty", 64'(empty), 64'd1);
    check("t7_no_stale_drain", 64'(drains - d0), 64'd0);
    bus.mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
